// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    LOAD,
    FLUSH,
    RUN,
    ERR
  } loader_state_t;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte link: valid/ready byte stream into the loader.
interface imem_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Lane counter plus shift register assembling little-endian words from bytes.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr_i,
  input  logic                        valid_i,
  input  logic [7:0]                  data_i,
  output logic [BYTES_PER_WORD*8-1:0] word_o,
  output logic                        word_done_o
);
  localparam int unsigned W      = BYTES_PER_WORD * 8;
  localparam int unsigned LANE_W = $clog2(BYTES_PER_WORD);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [W-1:0]      sr_q, sr_d;
  logic              last_lane;

  assign last_lane = (lane_q == LANE_W'(BYTES_PER_WORD - 1));

  // Bytes enter at the top so the first byte ends up in bits 7:0.
  assign word_o      = {data_i, sr_q[W-1:8]};
  assign word_done_o = valid_i && last_lane;

  always_comb begin
    lane_d = lane_q;
    sr_d   = sr_q;
    if (clr_i) begin
      lane_d = '0;
    end else if (valid_i) begin
      sr_d   = word_o;
      lane_d = lane_q + LANE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      sr_q   <= '0;
    end else begin
      lane_q <= lane_d;
      sr_q   <= sr_d;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a counted byte image, writes words to instruction memory, holds core reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter  int unsigned WIDTH   = 32,
  parameter  int unsigned SIZE    = 256,
  localparam int unsigned LOGSIZE = $clog2(SIZE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_req,
  imem_loader_if.slave       host,
  output logic [WIDTH-1:0]   instr_in,
  output logic [LOGSIZE+1:0] wr_addr,
  output logic               wr_en,
  output logic               core_reset,
  output logic               busy,
  output logic               error
);
  localparam int unsigned IDX_W = LOGSIZE + 1;

  loader_state_t      state_q, state_d;
  logic [15:0]        count_q, count_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   instr_q, instr_d;
  logic [LOGSIZE+1:0] addr_q, addr_d;
  logic               wr_en_q, wr_en_d;
  logic               core_reset_q, core_reset_d;

  logic               ready, accept, pk_clr, word_done;
  logic [15:0]        hdr_count;
  logic [WIDTH-1:0]   word;

  assign ready     = (state_q == HDR0) || (state_q == HDR1) || (state_q == LOAD);
  assign accept    = host.in_valid && ready;
  assign hdr_count = {host.in_data, count_q[7:0]};

  assign host.in_ready = ready;
  assign busy          = ready || (state_q == FLUSH);
  assign error         = (state_q == ERR);
  assign instr_in      = instr_q;
  assign wr_addr       = addr_q;
  assign wr_en         = wr_en_q;
  assign core_reset    = core_reset_q;

  byte_packer u_packer (
    .clk         (clk),
    .rst_n       (reset),
    .clr_i       (pk_clr),
    .valid_i     (accept && (state_q == LOAD)),
    .data_i      (host.in_data),
    .word_o      (word),
    .word_done_o (word_done)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    wr_en_d = 1'b0;
    pk_clr  = 1'b0;
    unique case (state_q)
      IDLE: if (load_req) state_d = HDR0;
      HDR0: if (accept) begin
        count_d[7:0] = host.in_data;
        state_d      = HDR1;
      end
      HDR1: if (accept) begin
        count_d[15:8] = host.in_data;
        if (hdr_count == 16'd0 || hdr_count > 16'(SIZE)) begin
          state_d = ERR;
        end else begin
          idx_d   = '0;
          pk_clr  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: if (word_done) begin
        instr_d = word;
        addr_d  = {idx_q[LOGSIZE-1:0], 2'b00};
        wr_en_d = 1'b1;
        idx_d   = idx_q + IDX_W'(1);
        if (16'(idx_q) == count_q - 16'd1) state_d = FLUSH;
      end
      FLUSH: state_d = RUN;
      RUN, ERR: if (load_req) state_d = HDR0;
      default: state_d = IDLE;
    endcase
    // Registered from next state so release and re-hold line up with the transition edge.
    core_reset_d = (state_d != RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      idx_q        <= '0;
      instr_q      <= '0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      instr_q      <= instr_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      core_reset_q <= core_reset_d;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;
  localparam int unsigned SIZE = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_req = 1'b0;
  logic [31:0] instr_in;
  logic [9:0]  wr_addr;
  logic        wr_en, core_reset, busy, error;

  imem_loader_if host_if ();

  imem_loader #(.WIDTH(32), .SIZE(SIZE)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_req   (load_req),
    .host       (host_if),
    .instr_in   (instr_in),
    .wr_addr    (wr_addr),
    .wr_en      (wr_en),
    .core_reset (core_reset),
    .busy       (busy),
    .error      (error)
  );

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  logic [41:0] wq[$];
  logic [7:0]  img[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (wr_en === 1'b1) wq.push_back({wr_addr, instr_in});

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    host_if.in_data  = b;
    host_if.in_valid = 1'b1;
    while (host_if.in_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL send_timeout in_ready=%b required=1", host_if.in_ready);
    end
    step();
    host_if.in_valid = 1'b0;
  endtask

  task automatic send_image(input bit gap);
    foreach (img[i]) begin
      send_byte(img[i]);
      if (gap) step();
    end
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  task automatic set_two_word();
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'hA0, 8'h00};
  endtask

  task automatic test_reset();
    host_if.in_valid = 1'b0;
    host_if.in_data  = 8'h00;
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL rst_core_reset got=%b want=1", core_reset); end
    checks++; if (host_if.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b want=0", host_if.in_ready); end
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%b want=0", wr_en); end
    checks++; if ({busy, error} !== 2'b00) begin failures++; $display("FAIL rst_busy_err got=%b want=00", {busy, error}); end
    checks++; if (instr_in !== 32'h0 || wr_addr !== 10'h0) begin failures++; $display("FAIL rst_port got=%h/%h want=0/0", instr_in, wr_addr); end
    host_if.in_data = 8'hAA;
    repeat (3) begin
      host_if.in_valid = 1'b1; step();
      host_if.in_valid = 1'b0; step();
    end
    checks++; if (busy !== 1'b0 || core_reset !== 1'b1) begin failures++; $display("FAIL idle_ignore busy/core_reset got=%b%b want=01", busy, core_reset); end
    checks++; if (wq.size() != 0) begin failures++; $display("FAIL idle_no_write writes=%0d want=0", wq.size()); end
  endtask

  task automatic test_two_word();
    logic [41:0] w0, w1;
    wq.delete();
    set_two_word();
    pulse_load();
    checks++; if ({busy, host_if.in_ready, core_reset, error} !== 4'b1110) begin failures++; $display("FAIL hdr0_flags got=%b want=1110", {busy, host_if.in_ready, core_reset, error}); end
    for (int i = 0; i < 6; i++) send_byte(img[i]);
    checks++; if (wr_en !== 1'b1 || wr_addr !== 10'h000 || instr_in !== 32'h00000013) begin failures++; $display("FAIL w0_strobe got=%b/%h/%h want=1/000/00000013", wr_en, wr_addr, instr_in); end
    send_byte(img[6]);
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL w0_one_cycle got=%b want=0", wr_en); end
    for (int i = 7; i < 10; i++) send_byte(img[i]);
    checks++; if (wr_en !== 1'b1 || wr_addr !== 10'h004 || instr_in !== 32'h00A000B3) begin failures++; $display("FAIL w1_flush got=%b/%h/%h want=1/004/00a000b3", wr_en, wr_addr, instr_in); end
    checks++; if (core_reset !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL flush_hold core_reset/busy got=%b%b want=11", core_reset, busy); end
    step();
    checks++; if ({core_reset, wr_en, busy, host_if.in_ready} !== 4'b0000) begin failures++; $display("FAIL run_release got=%b want=0000", {core_reset, wr_en, busy, host_if.in_ready}); end
    w0 = (wq.size() > 0) ? wq[0] : 'x;
    w1 = (wq.size() > 1) ? wq[1] : 'x;
    checks++; if (wq.size() != 2 || w0 !== {10'h000, 32'h00000013} || w1 !== {10'h004, 32'h00A000B3}) begin failures++; $display("FAIL two_word_writes n=%0d got=%h,%h want=2 writes", wq.size(), w0, w1); end
  endtask

  task automatic test_gapped();
    logic [41:0] w0, w1;
    wq.delete();
    set_two_word();
    pulse_load();
    send_image(1'b1);
    w0 = (wq.size() > 0) ? wq[0] : 'x;
    w1 = (wq.size() > 1) ? wq[1] : 'x;
    checks++; if (wq.size() != 2 || w0 !== {10'h000, 32'h00000013} || w1 !== {10'h004, 32'h00A000B3}) begin failures++; $display("FAIL gapped_writes n=%0d got=%h,%h want=2 writes", wq.size(), w0, w1); end
    checks++; if (core_reset !== 1'b0) begin failures++; $display("FAIL gapped_run core_reset=%b want=0", core_reset); end
  endtask

  task automatic test_bad_counts();
    logic [41:0] w0, w1;
    wq.delete();
    pulse_load();
    img = '{8'h00, 8'h00};
    send_image(1'b0);
    checks++; if ({error, busy, host_if.in_ready, core_reset} !== 4'b1001) begin failures++; $display("FAIL zero_count_err got=%b want=1001", {error, busy, host_if.in_ready, core_reset}); end
    pulse_load();
    checks++; if (error !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL err_clear error/busy got=%b%b want=01", error, busy); end
    img = '{8'h01, 8'h01};
    send_image(1'b0);
    checks++; if (error !== 1'b1 || core_reset !== 1'b1) begin failures++; $display("FAIL count257_err error/core_reset got=%b%b want=11", error, core_reset); end
    checks++; if (wq.size() != 0) begin failures++; $display("FAIL bad_no_write writes=%0d want=0", wq.size()); end
    pulse_load();
    set_two_word();
    send_image(1'b0);
    step();
    checks++; if (error !== 1'b0 || core_reset !== 1'b0) begin failures++; $display("FAIL err_recover error/core_reset got=%b%b want=00", error, core_reset); end
    w0 = (wq.size() > 0) ? wq[0] : 'x;
    w1 = (wq.size() > 1) ? wq[1] : 'x;
    checks++; if (wq.size() != 2 || w0 !== {10'h000, 32'h00000013} || w1 !== {10'h004, 32'h00A000B3}) begin failures++; $display("FAIL recover_writes n=%0d got=%h,%h want=2 writes", wq.size(), w0, w1); end
  endtask

  task automatic test_full();
    int unsigned c0;
    int          errs = 0;
    logic [7:0]  b;
    logic [41:0] exp_w;
    wq.delete();
    img = '{8'h00, 8'h01};
    for (int unsigned i = 0; i < SIZE; i++) begin
      b = 8'(i);
      img.push_back(b);
      img.push_back(8'h5A);
      img.push_back(~b);
      img.push_back(8'hC3);
    end
    pulse_load();
    c0 = cyc;
    send_image(1'b0);
    checks++; if (wr_en !== 1'b1 || wr_addr !== 10'h3FC || core_reset !== 1'b1) begin failures++; $display("FAIL full_last got=%b/%h/%b want=1/3fc/1", wr_en, wr_addr, core_reset); end
    step();
    checks++; if (core_reset !== 1'b0 || cyc - c0 != 1027) begin failures++; $display("FAIL full_release core_reset=%b cycles=%0d want=0/1027", core_reset, cyc - c0); end
    checks++; if (wq.size() != SIZE) begin failures++; $display("FAIL full_count writes=%0d want=%0d", wq.size(), SIZE); end
    foreach (wq[i]) begin
      b = 8'(i);
      exp_w = {10'(i * 4), 8'hC3, ~b, 8'h5A, b};
      if (wq[i] !== exp_w) begin
        errs++;
        if (errs < 4) $display("FAIL full_word[%0d] got=%h want=%h", i, wq[i], exp_w);
      end
    end
    checks++; if (errs != 0) begin failures++; $display("FAIL full_words bad=%0d want=0", errs); end
  endtask

  task automatic test_reload_abort();
    wq.delete();
    set_two_word();
    load_req = 1'b1;
    step();
    checks++; if ({core_reset, busy, error} !== 3'b110) begin failures++; $display("FAIL reload_hold got=%b want=110", {core_reset, busy, error}); end
    for (int i = 0; i < 6; i++) send_byte(img[i]);
    checks++; if (wr_en !== 1'b1 || wr_addr !== 10'h000 || instr_in !== 32'h00000013) begin failures++; $display("FAIL reload_w0 got=%b/%h/%h want=1/000/00000013", wr_en, wr_addr, instr_in); end
    load_req = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if ({wr_en, core_reset, busy, host_if.in_ready} !== 4'b0100) begin failures++; $display("FAIL abort_async got=%b want=0100", {wr_en, core_reset, busy, host_if.in_ready}); end
    checks++; if (instr_in !== 32'h0 || wr_addr !== 10'h0) begin failures++; $display("FAIL abort_port got=%h/%h want=0/0", instr_in, wr_addr); end
    step();
    reset = 1'b1;
    step();
    checks++; if ({core_reset, busy, error} !== 3'b100) begin failures++; $display("FAIL abort_idle got=%b want=100", {core_reset, busy, error}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_two_word();
    test_gapped();
    test_bad_counts();
    test_full();
    test_reload_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
